// File: rtl/sr_pair_sequencer_pkg.sv
// Shared definitions for the instruction-pair sequencer.
//   - Default widths: XLEN for addresses, CNT_W for the performance counters.
//   - seq_state_e: the sequencer state codes.
//   - SLOT_* constants: the values driven on iss_slot.
//   - entry_state(): picks the first state for a newly accepted pair from its mask.
package sr_pair_sequencer_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_ISS0 = 2'd1,
    SEQ_ISS1 = 2'd2
  } seq_state_e;

  localparam logic [1:0] SLOT_NONE = 2'd0;
  localparam logic [1:0] SLOT_0    = 2'd1;
  localparam logic [1:0] SLOT_1    = 2'd2;

  // An empty mask drops the pair without issuing anything.
  function automatic seq_state_e entry_state(input logic [1:0] mask);
    if (mask[0])      return SEQ_ISS0;
    else if (mask[1]) return SEQ_ISS1;
    else              return SEQ_IDLE;
  endfunction

endpackage

// File: rtl/sr_pair_sequencer_if.sv
// Interface for the sequencer's fetch-side and datapath-side handshakes.
//   - master: the environment (fetch and datapath). It drives pair_*, exec_ready and br_taken.
//   - slave: the sequencer. It drives pair_ready, iss_* and flush.
interface sr_pair_sequencer_if
  import sr_pair_sequencer_pkg::*;
#(
  parameter int XLEN_P = XLEN
);
  logic              pair_valid;
  logic              pair_ready;
  logic [XLEN_P-1:0] pair_addr;
  logic [31:0]       pair_instr0;
  logic [31:0]       pair_instr1;
  logic [1:0]        pair_mask;
  logic              iss_valid;
  logic [31:0]       iss_instr;
  logic [XLEN_P-1:0] iss_addr;
  logic [1:0]        iss_slot;
  logic              exec_ready;
  logic              br_taken;
  logic              flush;

  modport master (
    output pair_valid, pair_addr, pair_instr0, pair_instr1, pair_mask, exec_ready, br_taken,
    input  pair_ready, iss_valid, iss_instr, iss_addr, iss_slot, flush
  );

  modport slave (
    input  pair_valid, pair_addr, pair_instr0, pair_instr1, pair_mask, exec_ready, br_taken,
    output pair_ready, iss_valid, iss_instr, iss_addr, iss_slot, flush
  );
endinterface

// File: rtl/sr_sat_counter.sv
// Saturating up-counter used for the performance counters.
// Ports:
//   - clk, rst_n: clock and asynchronous active-low reset.
//   - inc_i: count one event this cycle.
//   - cnt_o: the count. It stops at all-ones.
module sr_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt_q <= '0;
    else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/sr_pair_sequencer.sv
// Accepts an instruction pair from fetch. Slot0 sits at addr and slot1 at addr+4.
// The pair is issued one instruction per cycle, in program order, to the shared datapath.
// A taken branch in the presented slot kills the younger slot.
// It also raises a one-cycle flush pulse so fetch redirects.
// Ports:
//   - clk, rst_n: clock and asynchronous active-low reset.
//   - bus: pair and issue handshakes, plus flush (slave modport).
//   - cnt_issued_o: saturating count of consumed instructions.
//   - cnt_killed_o: saturating count of slot1 instructions killed by a slot0 taken branch.
//
// state    | meaning
// SEQ_IDLE | buffer empty, ready for a pair
// SEQ_ISS0 | presenting slot0 of the buffered pair
// SEQ_ISS1 | presenting slot1; a new pair may be accepted on its consume
module sr_pair_sequencer
  import sr_pair_sequencer_pkg::*;
#(
  parameter int CNT_W_P = CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_pair_sequencer_if.slave bus,
  output logic [CNT_W_P-1:0] cnt_issued_o,
  output logic [CNT_W_P-1:0] cnt_killed_o
);
  seq_state_e       state_q, state_d;
  logic [31:0]      instr0_q, instr1_q;
  logic [XLEN-1:0]  addr0_q, addr1_q;
  logic [1:0]       mask_q;
  logic             flush_q, flush_d;
  logic             pair_ready, accept, consume, kill;

  assign consume = (state_q != SEQ_IDLE) && bus.exec_ready;
  assign accept  = bus.pair_valid && pair_ready;

  always_comb begin
    state_d    = state_q;
    pair_ready = 1'b0;
    flush_d    = 1'b0;
    kill       = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        pair_ready = 1'b1;
        if (bus.pair_valid) state_d = entry_state(bus.pair_mask);
      end
      SEQ_ISS0: begin
        if (consume) begin
          if (bus.br_taken) begin
            state_d = SEQ_IDLE;
            flush_d = 1'b1;
            kill    = mask_q[1];
          end else begin
            state_d = mask_q[1] ? SEQ_ISS1 : SEQ_IDLE;
          end
        end
      end
      SEQ_ISS1: begin
        if (consume) begin
          if (bus.br_taken) begin
            state_d = SEQ_IDLE;
            flush_d = 1'b1;
          end else begin
            // A pair accepted on this consume issues next cycle, so there is no bubble.
            pair_ready = 1'b1;
            state_d    = bus.pair_valid ? entry_state(bus.pair_mask) : SEQ_IDLE;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEQ_IDLE;
      instr0_q <= '0;
      instr1_q <= '0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      mask_q   <= '0;
      flush_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      if (accept) begin
        instr0_q <= bus.pair_instr0;
        instr1_q <= bus.pair_instr1;
        addr0_q  <= bus.pair_addr;
        addr1_q  <= bus.pair_addr + XLEN'(4);
        mask_q   <= bus.pair_mask;
      end
    end
  end

  // The issue outputs come only from registered state, never from the pair_* inputs.
  always_comb begin
    bus.iss_valid = 1'b0;
    bus.iss_instr = '0;
    bus.iss_addr  = '0;
    bus.iss_slot  = SLOT_NONE;
    case (state_q)
      SEQ_ISS0: begin
        bus.iss_valid = 1'b1;
        bus.iss_instr = instr0_q;
        bus.iss_addr  = addr0_q;
        bus.iss_slot  = SLOT_0;
      end
      SEQ_ISS1: begin
        bus.iss_valid = 1'b1;
        bus.iss_instr = instr1_q;
        bus.iss_addr  = addr1_q;
        bus.iss_slot  = SLOT_1;
      end
      default: ;
    endcase
  end

  assign bus.pair_ready = pair_ready;
  assign bus.flush      = flush_q;

  sr_sat_counter #(.CNT_W(CNT_W_P)) u_cnt_issued (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (consume),
    .cnt_o (cnt_issued_o)
  );

  sr_sat_counter #(.CNT_W(CNT_W_P)) u_cnt_killed (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (kill),
    .cnt_o (cnt_killed_o)
  );
endmodule
